// File: rtl/flag_writeback.sv
// flag_writeback: result buffer and flag register placed after the SUB stage.
//
// Each result accepted from SUB goes into a small FIFO and waits there for the
// writeback consumer. The flag register is updated when the result is pushed,
// not when it is popped, so the next SUB op sees fresh flags one cycle later.
// Cond_Pass evaluates a condition code against the committed flags.
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   In_Valid / In_Ready        push handshake from SUB
//   Result, New_Flag, S        pushed payload; S=1 commits New_Flag to Flag
//   Cond / Cond_Pass           condition code and its evaluation against Flag
//   Flag                       committed {N,Z,C,V}, fed back to SUB
//   Out_Valid / Out_Ready      pop handshake to the writeback consumer
//   Out_Result, Out_Flag       head entry; both read 0 while the buffer is empty
//   Ovf_Count                  saturating count of committed V=1 updates
module flag_writeback #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic signed [WIDTH-1:0] Result,
    input  logic [3:0]              New_Flag,
    input  logic                    S,
    input  logic [3:0]              Cond,
    output logic [3:0]              Flag,
    output logic                    Cond_Pass,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [WIDTH-1:0]        Out_Result,
    output logic [3:0]              Out_Flag,
    output logic [7:0]              Ovf_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       flag;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    // Ready depends on registered occupancy only, so a full buffer refuses a
    // push even in a cycle where the head is being popped.
    assign In_Ready  = (count < CW'(DEPTH));
    assign Out_Valid = (count != '0);
    assign push      = In_Valid & In_Ready;
    assign pop       = Out_Valid & Out_Ready;

    // Gating the head with Out_Valid makes the outputs read 0 after reset
    // without having to clear the storage array.
    assign Out_Result = Out_Valid ? mem[rd_ptr].result : '0;
    assign Out_Flag   = Out_Valid ? mem[rd_ptr].flag   : '0;

    // Storage carries no reset; entries are only ever observed through
    // the occupancy-gated head above.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= '{result: Result, flag: New_Flag};
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Flag      <= 4'b0000;
            Ovf_Count <= 8'd0;
        end else if (push && S) begin
            Flag <= New_Flag;
            if (New_Flag[0] && Ovf_Count != 8'hFF)
                Ovf_Count <= Ovf_Count + 8'd1;
        end
    end

    // Condition codes follow the ARM ordering.
    logic n, z, c, v;
    assign {n, z, c, v} = Flag;

    always_comb begin
        Cond_Pass = 1'b0;
        case (Cond)
            4'd0:  Cond_Pass = z;
            4'd1:  Cond_Pass = ~z;
            4'd2:  Cond_Pass = c;
            4'd3:  Cond_Pass = ~c;
            4'd4:  Cond_Pass = n;
            4'd5:  Cond_Pass = ~n;
            4'd6:  Cond_Pass = v;
            4'd7:  Cond_Pass = ~v;
            4'd8:  Cond_Pass = c & ~z;
            4'd9:  Cond_Pass = ~c | z;
            4'd10: Cond_Pass = (n == v);
            4'd11: Cond_Pass = (n != v);
            4'd12: Cond_Pass = ~z & (n == v);
            4'd13: Cond_Pass = z | (n != v);
            4'd14: Cond_Pass = 1'b1;
            default: Cond_Pass = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flag_writeback.sv
// tb_flag_writeback: directed sequences, a condition-code vector table, and a
// randomized run checked against a queue-based reference model.
module tb_flag_writeback;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               In_Valid;
    logic               In_Ready;
    logic signed [31:0] Result;
    logic [3:0]         New_Flag;
    logic               S;
    logic [3:0]         Cond;
    logic [3:0]         Flag;
    logic               Cond_Pass;
    logic               Out_Valid;
    logic               Out_Ready;
    logic [31:0]        Out_Result;
    logic [3:0]         Out_Flag;
    logic [7:0]         Ovf_Count;

    int nvec = 0;
    int nerr = 0;

    flag_writeback #(.WIDTH(32), .DEPTH(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Result(Result), .New_Flag(New_Flag), .S(S), .Cond(Cond),
        .Flag(Flag), .Cond_Pass(Cond_Pass),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Result(Out_Result), .Out_Flag(Out_Flag), .Ovf_Count(Ovf_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] r, input logic [3:0] nf,
                         input logic s, input logic ordy);
        In_Valid  = iv;
        Result    = r;
        New_Flag  = nf;
        S         = s;
        Out_Ready = ordy;
    endtask

    // Reference condition evaluation: predicates come in true/inverted pairs,
    // Cond[0] selects the inverted form.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    typedef struct {
        logic [3:0] nflag;
        logic [3:0] cond;
        logic       exp_pass;
    } cvec_t;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
    } ment_t;

    cvec_t cv [18];
    ment_t mq [$];

    initial begin
        logic [3:0] mflag;
        int         movf;
        logic       mpush, mpop;

        cv[0]  = '{4'b0100, 4'd0,  1'b1};
        cv[1]  = '{4'b0100, 4'd1,  1'b0};
        cv[2]  = '{4'b0010, 4'd2,  1'b1};
        cv[3]  = '{4'b0010, 4'd3,  1'b0};
        cv[4]  = '{4'b0000, 4'd4,  1'b0};
        cv[5]  = '{4'b0000, 4'd5,  1'b1};
        cv[6]  = '{4'b0001, 4'd6,  1'b1};
        cv[7]  = '{4'b0000, 4'd7,  1'b1};
        cv[8]  = '{4'b0110, 4'd8,  1'b0};
        cv[9]  = '{4'b0010, 4'd8,  1'b1};
        cv[10] = '{4'b0010, 4'd9,  1'b0};
        cv[11] = '{4'b1001, 4'd10, 1'b1};
        cv[12] = '{4'b1000, 4'd11, 1'b1};
        cv[13] = '{4'b0000, 4'd12, 1'b1};
        cv[14] = '{4'b0100, 4'd12, 1'b0};
        cv[15] = '{4'b0001, 4'd13, 1'b1};
        cv[16] = '{4'b1111, 4'd14, 1'b1};
        cv[17] = '{4'b0000, 4'd15, 1'b0};

        Reset = 1'b1;
        Cond  = 4'd0;
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);

        // reset state
        repeat (2) step();
        check("rst_out_valid",  Out_Valid,  0);
        check("rst_in_ready",   In_Ready,   1);
        check("rst_flag",       Flag,       0);
        check("rst_ovf",        Ovf_Count,  0);
        check("rst_out_result", Out_Result, 0);
        check("rst_out_flag",   Out_Flag,   0);
        Reset = 1'b0;

        // single op, also the first push after reset release
        Cond = 4'd4;
        drive(1'b1, 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b1);
        step();
        check("single_out_valid",  Out_Valid,  1);
        check("single_out_result", Out_Result, 32'hFFFF_FFFF);
        check("single_flag",       Flag,       4'b1000);
        check("single_cond_pass",  Cond_Pass,  1);

        // S=0 leaves the flag register alone
        drive(1'b1, 32'd0, 4'b0100, 1'b0, 1'b1);
        step();
        check("hold_flag",       Flag,       4'b1000);
        check("hold_out_flag",   Out_Flag,   4'b0100);
        check("hold_out_result", Out_Result, 0);
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
        step();
        check("hold_drained", Out_Valid, 0);

        // fill and backpressure
        drive(1'b1, 32'd4, 4'd0, 1'b0, 1'b0);
        step();
        check("fill1_in_ready", In_Ready, 1);
        drive(1'b1, 32'd10, 4'd0, 1'b0, 1'b0);
        step();
        check("fill2_in_ready", In_Ready,   0);
        check("fill2_head",     Out_Result, 4);
        drive(1'b1, 32'd99, 4'd0, 1'b0, 1'b0);
        step();
        check("full_head_stable", Out_Result, 4);
        check("full_in_ready",    In_Ready,   0);
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
        step();
        check("drain_second",   Out_Result, 10);
        check("drain_in_ready", In_Ready,   1);
        step();
        check("drain_empty", Out_Valid, 0);

        // simultaneous push/pop at occupancy 1, pointers wrap repeatedly
        drive(1'b1, 32'd100, 4'd0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(101 + i), 4'd0, 1'b0, 1'b1);
            step();
            check("pp_valid",    Out_Valid,  1);
            check("pp_in_ready", In_Ready,   1);
            check("pp_order",    Out_Result, 32'(101 + i));
        end
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
        step();
        check("pp_drained", Out_Valid, 0);

        // overflow counter saturation
        Cond = 4'd6;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'(i), 4'b0001, 1'b1, 1'b1);
            step();
            if (i == 99)  check("ovf_100", Ovf_Count, 100);
            if (i == 254) check("ovf_255", Ovf_Count, 255);
        end
        check("ovf_sat",       Ovf_Count, 255);
        check("ovf_cond_pass", Cond_Pass, 1);
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
        step();

        // reset in the middle of a cycle with two entries buffered
        drive(1'b1, 32'd7, 4'b0110, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'd8, 4'b0000, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        check("pre_rst_valid", Out_Valid, 1);
        check("pre_rst_flag",  Flag,      4'b0110);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_valid",    Out_Valid,  0);
        check("mid_rst_flag",     Flag,       0);
        check("mid_rst_ovf",      Ovf_Count,  0);
        check("mid_rst_in_ready", In_Ready,   1);
        check("mid_rst_result",   Out_Result, 0);
        step();
        Reset = 1'b0;
        Out_Ready = 1'b1;
        step();
        check("post_rst_no_stale", Out_Valid, 0);

        // condition-code table
        for (int i = 0; i < 18; i++) begin
            Cond = cv[i].cond;
            drive(1'b1, 32'(i), cv[i].nflag, 1'b1, 1'b1);
            step();
            check("tbl_flag", Flag,      cv[i].nflag);
            check("tbl_cond", Cond_Pass, cv[i].exp_pass);
        end
        drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
        step();

        // randomized run against the reference model
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        mq.delete();
        mflag = 4'd0;
        movf  = 0;
        for (int i = 0; i < 400; i++) begin
            In_Valid  = 1'($urandom_range(0, 1));
            Result    = $urandom;
            New_Flag  = 4'($urandom_range(0, 15));
            S         = 1'($urandom_range(0, 1));
            Cond      = 4'($urandom_range(0, 15));
            Out_Ready = ($urandom_range(0, 3) != 0);
            mpush = In_Valid && (mq.size() < 2);
            mpop  = Out_Ready && (mq.size() > 0);
            step();
            if (mpop)  void'(mq.pop_front());
            if (mpush) mq.push_back('{Result, New_Flag});
            if (mpush && S) begin
                mflag = New_Flag;
                if (New_Flag[0] && movf < 255) movf++;
            end
            check("rnd_out_valid", Out_Valid, (mq.size() > 0));
            check("rnd_in_ready",  In_Ready,  (mq.size() < 2));
            check("rnd_flag",      Flag,      mflag);
            check("rnd_ovf",       Ovf_Count, movf);
            check("rnd_cond",      Cond_Pass, cond_model(Cond, mflag));
            if (mq.size() > 0) begin
                check("rnd_out_result", Out_Result, mq[0].r);
                check("rnd_out_flag",   Out_Flag,   mq[0].f);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/flag_writeback.md
FLAG_WRITEBACK -- requirements
Module: flag_writeback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the result datapath width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the result-buffer entry count; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
  Clk  input  1  single clock; all state changes on rising edge.
  Reset  input  1  asynchronous, active-high reset.
  In_Valid  input  1  SUB stage presents a result this cycle.
  In_Ready  output  1  block can accept a result this cycle.
  Result  input  WIDTH  signed result from SUB.
  New_Flag  input  4  {N,Z,C,V} produced by SUB.
  S  input  1  set-flags qualifier of the presented op.
  Cond  input  4  condition code to evaluate against the flag register.
  Flag  output  4  committed {N,Z,C,V} register, fed back to the SUB Flag input.
  Cond_Pass  output  1  Cond evaluated against Flag.
  Out_Valid  output  1  buffer head is valid for writeback.
  Out_Ready  input  1  writeback consumer takes the head this cycle.
  Out_Result  output  WIDTH  buffer head result.
  Out_Flag  output  4  New_Flag value captured with the buffer head.
  Ovf_Count  output  8  saturating count of committed V=1 updates.

Function
REQ-004 Push SHALL occur when In_Valid=1 and In_Ready=1; pop SHALL occur when Out_Valid=1 and Out_Ready=1.
REQ-005 In_Ready SHALL be 1 exactly when occupancy < DEPTH; it is a function of registered occupancy only and has no combinational path from Out_Ready.
REQ-006 The buffer SHALL be FIFO-ordered with pointers that wrap modulo DEPTH; occupancy SHALL be held in a log2(DEPTH)+1 bit counter.
REQ-007 Out_Valid SHALL be 1 exactly when occupancy > 0; Out_Result and Out_Flag SHALL show the head entry and SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-008 Latency SHALL be one cycle: a result pushed at edge k SHALL be visible on Out_Result after edge k; there is no same-cycle bypass.
REQ-009 Simultaneous push and pop SHALL leave occupancy unchanged and SHALL preserve ordering.
REQ-010 Pop while empty and push while full SHALL have no effect, because the handshake gates them.
REQ-011 On a push with S=1, Flag SHALL load New_Flag at that edge; on a push with S=0, or with no push, Flag SHALL hold its value.
REQ-012 Flag SHALL update at push time, independent of when the entry is popped, so that the next SUB op sees the flags in the following cycle.
REQ-013 On a push with S=1 and New_Flag[0]=1, Ovf_Count SHALL increment by 1 and SHALL saturate at 255.
REQ-014 Cond_Pass SHALL be combinational from Cond and Flag, with N=Flag[3], Z=Flag[2], C=Flag[1], V=Flag[0]:
  0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V; 8 C&!Z; 9 !C|Z; 10 N==V; 11 N!=V; 12 !Z&(N==V); 13 Z|(N!=V); 14 always 1; 15 always 0.
REQ-015 Result SHALL be stored unmodified as a WIDTH-bit value; the block SHALL perform no arithmetic on it.

Reset
REQ-016 Reset=1 SHALL, asynchronously and without waiting for Clk, clear the occupancy counter and pointers, Flag, and Ovf_Count.
REQ-017 While Reset=1, Out_Valid SHALL be 0, In_Ready SHALL be 1, Flag SHALL be 4'b0000, Ovf_Count SHALL be 0, and Out_Result and Out_Flag SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL discard all buffered entries; no entry pushed before reset SHALL appear at the output afterwards.
REQ-019 The first push SHALL be accepted on the first rising edge after Reset deasserts.

Verification
REQ-020 The bench SHALL cover a single op: push Result=-1, New_Flag=1000, S=1, with Out_Ready=1 -> next cycle Out_Valid=1, Out_Result=-1, Flag=1000, and Cond=4 gives Cond_Pass=1.
REQ-021 The bench SHALL cover S=0 hold: with Flag=1000, push Result=0, New_Flag=0100, S=0 -> Flag stays 1000 and Out_Flag=0100.
REQ-022 The bench SHALL cover fill and backpressure: with Out_Ready=0, push 4 then 10 -> In_Ready=0 after the 2nd edge and a 3rd push is ignored; then raise Out_Ready -> Out_Result shows 4 then 10, and In_Ready returns to 1.
REQ-023 The bench SHALL cover simultaneous push and pop at occupancy 1 over 20 cycles -> occupancy stays 1, results stay in order, and pointers wrap without loss.
REQ-024 The bench SHALL cover overflow saturation: 300 pushes with S=1, New_Flag=0001 -> Ovf_Count=255 and Cond=6 gives Cond_Pass=1.
REQ-025 The bench SHALL cover reset mid-operation: with 2 entries buffered and Flag=0110, assert Reset between edges -> Out_Valid=0, Flag=0000, and Ovf_Count=0 immediately.
